ysyx_24100006_lsu: RTL and testbench
====================================

// Module: ysyx_24100006_lsu
// PURPOSE
//  Parametrised load/store stage between EXEU and WBU; successor to the fixed-latency memory stage.
//  Registers one op per handshake and issues it as a request on a variable-latency memory bus.
//  Aligns, sign/zero-extends loads; builds byte strobes for stores; flags misaligned/bus faults.
//  Non-memory ops pass through with a single registered cycle and no bus traffic.
// PARAMETERS
//  XLEN     32  data width in bits (32 or 64); STRB = XLEN/8 strobe width
//  ADDR_W   32  address width
//  SB_W     64  opaque sideband width (pc, rd idx, csr data, ctrl) carried through to WBU
//  TMO_CYC  255 max cycles waiting for rsp_valid (used only with TIMEOUT feature)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  exe_valid   in   1       upstream op valid
//  mem_ready   out  1       stage can accept op
//  in_addr     in   ADDR_W  effective address (ALU result)
//  in_wdata    in   XLEN    store data (rs2)
//  in_ren      in   1       load op
//  in_wen      in   1       store op (in_ren&in_wen treated as store)
//  in_size     in   2       0=B 1=H 2=W 3=D (D legal only if XLEN=64)
//  in_unsigned in   1       zero-extend load
//  in_sb       in   SB_W    sideband
//  mem_valid   out  1       result valid to WBU
//  wb_ready    in   1       WBU accepts result
//  out_rdata   out  XLEN    extended load data (0 for non-load)
//  out_addr    out  ADDR_W  registered in_addr
//  out_sb      out  SB_W    registered in_sb
//  out_fault   out  2       0 none, 1 misaligned, 2 bus error, 3 timeout
//  req_valid / req_ready  out/in 1   bus request handshake
//  req_addr    out  ADDR_W  in_addr aligned down to STRB bytes
//  req_wen     out  1       write request
//  req_wstrb   out  STRB    byte strobes = size mask << offset
//  req_wdata   out  XLEN    store data << (offset*8)
//  rsp_valid   in   1       response (always accepted, no rsp_ready)
//  rsp_rdata   in   XLEN    raw read word
//  rsp_err     in   1       bus error with response
// BEHAVIOUR
//  Reset: state IDLE, mem_ready=1, mem_valid=0, req_valid=0, out_*=0, timeout counter=0.
//  States: IDLE -> (accept, mem op, aligned) REQ; (accept, non-mem or misaligned) DONE.
//   REQ: req_valid=1, payload stable; req_ready=1 -> WAIT. WAIT: rsp_valid -> DONE.
//   DONE: mem_valid=1; wb_ready=1 -> IDLE. Accept = exe_valid & mem_ready (mem_ready=1 only in IDLE).
//  Latency: non-mem/faulted op 1 cycle accept->mem_valid; mem op >= 2 + bus wait cycles.
//  Same-cycle req_ready and rsp_valid in REQ: response captured, go directly to DONE.
//  rsp_valid outside WAIT/REQ ignored (stray response, no state change).
//  Misaligned: addr % (1<<size) != 0, or size=3 with XLEN=32 -> fault=1, no bus request, rdata=0.
//  Load: shifted = rsp_rdata >> (offset*8); extend from 8/16/32 bits per in_size/in_unsigned.
//  rsp_err=1 -> fault=2, out_rdata=0; store strobes/ data never issued twice.
//  Outputs held stable while mem_valid & !wb_ready.
//  Reset mid-transaction: immediate return to reset values; outstanding bus response dropped.
// CONFIGURATION
//  YSYX_24100006_LSU_TIMEOUT_EN defined: counter counts WAIT cycles; reaching TMO_CYC -> DONE,
//   fault=3, out_rdata=0; a later matching rsp_valid is ignored. Counter cleared on entering WAIT.
//  Undefined: no counter logic; WAIT holds indefinitely until rsp_valid.
// TESTING
//  Reset low mid-WAIT -> next cycle mem_ready=1, mem_valid=0, req_valid=0, out_fault=0.
//  LB addr 0x8000_0003, rsp_rdata 0x80FF_0000 -> req_addr 0x8000_0000, out_rdata 0xFFFF_FF80.
//  SH addr 0x102, wdata 0x1234 -> req_wstrb 4'b1100, req_wdata 0x1234_0000, req_wen=1.
//  LW addr 0x101 -> no req_valid, mem_valid next cycle, out_fault=1.
//  Load, req_ready held 0 for 5 cycles, rsp_err=1 -> req_valid stable 5 cycles, out_fault=2.
//  TIMEOUT_EN, TMO_CYC=4, no rsp -> mem_valid after 4 WAIT cycles, out_fault=3; wb_ready=0 holds outputs.

Source files
------------

// File: rtl/ysyx_24100006_lsu.sv
// Load/store stage: registers one op, issues it on a variable-latency bus, aligns/extends loads.
// Optional macro YSYX_24100006_LSU_TIMEOUT_EN bounds the response wait to TMO_CYC cycles.
module ysyx_24100006_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int SB_W    = 64,
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exe_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [SB_W-1:0]     in_sb,
  output logic                mem_valid,
  input  logic                wb_ready,
  output logic [XLEN-1:0]     out_rdata,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [SB_W-1:0]     out_sb,
  output logic [1:0]          out_fault,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [ADDR_W-1:0]   req_addr,
  output logic                req_wen,
  output logic [XLEN/8-1:0]   req_wstrb,
  output logic [XLEN-1:0]     req_wdata,
  input  logic                rsp_valid,
  input  logic [XLEN-1:0]     rsp_rdata,
  input  logic                rsp_err
);

  localparam int STRB  = XLEN / 8;
  localparam int OFF_W = $clog2(STRB);

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_MIS  = 2'd1;
  localparam logic [1:0] FLT_BUS  = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [1:0]       size_r;
  logic             uns_r;
  logic             load_r;
  logic [OFF_W-1:0] off_r;
  logic             acc_mem;
  logic             acc_mis;
  logic [XLEN-1:0]  rsp_ext;

`ifdef YSYX_24100006_LSU_TIMEOUT_EN
  localparam logic [1:0] FLT_TMO = 2'd3;
  localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  function automatic logic [STRB-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return STRB'(1);
      2'd1:    return STRB'(3);
      2'd2:    return STRB'(15);
      default: return '1;
    endcase
  endfunction

  // Doubleword access only exists on a 64-bit datapath.
  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return (XLEN == 32) ? 1'b1 : |a[2:0];
    endcase
  endfunction

  // Move the addressed lane to bit 0, push its top bit to the MSB, then shift back down.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [1:0] sz,
                                                  input logic uns);
    logic [XLEN-1:0]        shifted;
    logic signed [XLEN-1:0] lifted;
    logic signed [XLEN-1:0] ext_s;
    logic [6:0]             pad;
    shifted = raw >> {off, 3'b000};
    case (sz)
      2'd0:    pad = 7'(XLEN - 8);
      2'd1:    pad = 7'(XLEN - 16);
      2'd2:    pad = 7'(XLEN - 32);
      default: pad = 7'd0;
    endcase
    lifted = shifted << pad;
    if (uns) ext_s = $signed($unsigned(lifted) >> pad);
    else     ext_s = lifted >>> pad;
    return ext_s;
  endfunction

  always_comb begin
    acc_mem = in_ren | in_wen;
    acc_mis = misaligned(in_addr[2:0], in_size);
    rsp_ext = load_r ? load_extend(rsp_rdata, off_r, size_r, uns_r) : '0;
  end

  assign mem_ready = (state == IDLE);
  assign req_valid = (state == REQ);
  assign mem_valid = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_rdata <= '0;
      out_addr  <= '0;
      out_sb    <= '0;
      out_fault <= FLT_NONE;
      req_addr  <= '0;
      req_wen   <= 1'b0;
      req_wstrb <= '0;
      req_wdata <= '0;
      size_r    <= 2'd0;
      uns_r     <= 1'b0;
      load_r    <= 1'b0;
      off_r     <= '0;
`ifdef YSYX_24100006_LSU_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (exe_valid) begin
          out_addr  <= in_addr;
          out_sb    <= in_sb;
          out_rdata <= '0;
          size_r    <= in_size;
          uns_r     <= in_unsigned;
          load_r    <= in_ren & ~in_wen;
          off_r     <= in_addr[OFF_W-1:0];
          if (acc_mem && !acc_mis) begin
            state     <= REQ;
            out_fault <= FLT_NONE;
            req_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            req_wen   <= in_wen;
            req_wstrb <= size_mask(in_size) << in_addr[OFF_W-1:0];
            req_wdata <= in_wdata << {in_addr[OFF_W-1:0], 3'b000};
          end else begin
            state     <= DONE;
            out_fault <= acc_mem ? FLT_MIS : FLT_NONE;
          end
        end
        // A response arriving with the request handshake is taken immediately.
        REQ: if (req_ready) begin
          if (rsp_valid) begin
            out_fault <= rsp_err ? FLT_BUS : FLT_NONE;
            out_rdata <= rsp_err ? '0 : rsp_ext;
            state     <= DONE;
          end else begin
            state     <= WAIT;
`ifdef YSYX_24100006_LSU_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        WAIT: if (rsp_valid) begin
          out_fault <= rsp_err ? FLT_BUS : FLT_NONE;
          out_rdata <= rsp_err ? '0 : rsp_ext;
          state     <= DONE;
        end
`ifdef YSYX_24100006_LSU_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
          out_fault <= FLT_TMO;
          out_rdata <= '0;
          state     <= DONE;
        end else begin
          tmo_cnt   <= tmo_cnt + 1'b1;
        end
`endif
        DONE: if (wb_ready) state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Randomized bench for ysyx_24100006_lsu with a transaction-level reference model.
module tb_ysyx_24100006_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid, mem_ready;
  logic [31:0] in_addr, in_wdata;
  logic        in_ren, in_wen, in_unsigned;
  logic [1:0]  in_size;
  logic [63:0] in_sb;
  logic        mem_valid, wb_ready;
  logic [31:0] out_rdata, out_addr;
  logic [63:0] out_sb;
  logic [1:0]  out_fault;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  ysyx_24100006_lsu #(.XLEN(32), .ADDR_W(32), .SB_W(64), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .exe_valid(exe_valid), .mem_ready(mem_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_ren(in_ren), .in_wen(in_wen),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_sb(in_sb),
    .mem_valid(mem_valid), .wb_ready(wb_ready), .out_rdata(out_rdata),
    .out_addr(out_addr), .out_sb(out_sb), .out_fault(out_fault),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ren, wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [63:0] sb;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  req_dly, rsp_dly, wb_dly;
    logic        tmo;
  } op_t;

  typedef struct packed {
    logic        has_req;
    logic [31:0] req_addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  fault;
    logic [31:0] rdata;
  } exp_t;

  int tests = 0;
  int fails = 0;

  logic        exp_mem_ready, exp_mem_valid, exp_req_valid, exp_chk_out;
  logic [31:0] exp_req_addr, exp_req_wdata, exp_out_addr, exp_out_rdata;
  logic [3:0]  exp_req_wstrb;
  logic        exp_req_wen;
  logic [63:0] exp_out_sb;
  logic [1:0]  exp_out_fault;

  function automatic op_t mk_op(input logic ren, input logic wen, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err);
    op_t o;
    o = '0;
    o.ren = ren; o.wen = wen; o.size = size; o.uns = uns;
    o.addr = addr; o.wdata = wdata; o.rdata = rdata; o.err = err;
    o.sb = 64'h0123_4567_89AB_CDEF;
    o.rsp_dly = 4'd1;
    return o;
  endfunction

  // Expected result from the access rules, using plain integer arithmetic.
  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [63:0] off, nbytes, nbits, v;
    logic mem, mis;
    e = '0;
    off    = 64'(o.addr % 32'd4);
    nbytes = 64'd1 << o.size;
    nbits  = nbytes * 64'd8;
    mem    = o.ren | o.wen;
    mis    = mem && ((o.size == 2'd3) || ((64'(o.addr) % nbytes) != 64'd0));
    e.has_req  = mem && !mis;
    e.req_addr = o.addr - 32'(off);
    e.wstrb    = 4'(((64'd1 << nbytes) - 64'd1) << off);
    e.wdata    = 32'(64'(o.wdata) << (off * 64'd8));
    e.wen      = o.wen;
    if (!mem)       e.fault = 2'd0;
    else if (mis)   e.fault = 2'd1;
    else if (o.err) e.fault = 2'd2;
    else            e.fault = 2'd0;
    if (e.has_req && o.ren && !o.wen && !o.err) begin
      v = (64'(o.rdata) >> (off * 64'd8)) % (64'd1 << nbits);
      if (!o.uns && v >= (64'd1 << (nbits - 64'd1)))
        v = v + (64'd1 << 32) - (64'd1 << nbits);
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: pins the model, then checks the DUT on every falling edge.
  initial begin
    op_t  po;
    exp_t pe;
    po = mk_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0);
    pe = model(po);
    chk("pin_lb_rdata", 64'(pe.rdata), 64'hFFFF_FF80);
    chk("pin_lb_addr", 64'(pe.req_addr), 64'h8000_0000);
    po = mk_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 32'h0, 1'b0);
    pe = model(po);
    chk("pin_sh_strb", 64'(pe.wstrb), 64'hC);
    chk("pin_sh_wdata", 64'(pe.wdata), 64'h1234_0000);
    po = mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0);
    pe = model(po);
    chk("pin_lw_mis", 64'(pe.fault), 64'd1);
    po = mk_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h8001_0000, 1'b0);
    pe = model(po);
    chk("pin_lhu_rdata", 64'(pe.rdata), 64'h0000_8001);
    forever begin
      @(negedge clk);
      chk("mem_ready", 64'(mem_ready), 64'(exp_mem_ready));
      chk("mem_valid", 64'(mem_valid), 64'(exp_mem_valid));
      chk("req_valid", 64'(req_valid), 64'(exp_req_valid));
      if (exp_req_valid) begin
        chk("req_addr", 64'(req_addr), 64'(exp_req_addr));
        chk("req_wen", 64'(req_wen), 64'(exp_req_wen));
        chk("req_wstrb", 64'(req_wstrb), 64'(exp_req_wstrb));
        chk("req_wdata", 64'(req_wdata), 64'(exp_req_wdata));
      end
      if (exp_chk_out) begin
        chk("out_rdata", 64'(out_rdata), 64'(exp_out_rdata));
        chk("out_addr", 64'(out_addr), 64'(exp_out_addr));
        chk("out_sb", out_sb, exp_out_sb);
        chk("out_fault", 64'(out_fault), 64'(exp_out_fault));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    exp_mem_ready = 1'b1; exp_mem_valid = 1'b0; exp_req_valid = 1'b0; exp_chk_out = 1'b1;
    exp_out_rdata = '0; exp_out_addr = '0; exp_out_sb = '0; exp_out_fault = 2'd0;
  endtask

  task automatic load_req_exp(input exp_t e);
    exp_req_valid = 1'b1;
    exp_req_addr = e.req_addr; exp_req_wen = e.wen;
    exp_req_wstrb = e.wstrb; exp_req_wdata = e.wdata;
  endtask

  task automatic do_op(input op_t o, input exp_t e);
    exe_valid = 1'b1;
    in_ren = o.ren; in_wen = o.wen; in_size = o.size; in_unsigned = o.uns;
    in_addr = o.addr; in_wdata = o.wdata; in_sb = o.sb;
    rsp_valid = ($urandom_range(0, 3) == 0);
    rsp_rdata = $urandom; rsp_err = 1'($urandom);
    wb_ready = 1'($urandom);
    cyc();
    exe_valid = 1'b0;
    in_ren = 1'($urandom); in_wen = 1'($urandom); in_size = 2'($urandom);
    in_unsigned = 1'($urandom); in_addr = $urandom; in_wdata = $urandom;
    in_sb = {$urandom, $urandom};
    rsp_valid = 1'b0; wb_ready = 1'b0;
    exp_mem_ready = 1'b0;
    exp_out_addr = o.addr; exp_out_sb = o.sb;
    exp_out_fault = e.fault; exp_out_rdata = e.rdata;
    if (e.has_req) begin
      load_req_exp(e);
      repeat (o.req_dly) cyc();
      req_ready = 1'b1;
      if (o.rsp_dly == 4'd0 && !o.tmo) begin
        rsp_valid = 1'b1; rsp_rdata = o.rdata; rsp_err = o.err;
      end
      cyc();
      req_ready = 1'b0; rsp_valid = 1'b0;
      rsp_rdata = $urandom; rsp_err = 1'($urandom);
      exp_req_valid = 1'b0;
      if (o.tmo) begin
        repeat (TMO) cyc();
      end else if (o.rsp_dly != 4'd0) begin
        repeat (o.rsp_dly - 4'd1) cyc();
        rsp_valid = 1'b1; rsp_rdata = o.rdata; rsp_err = o.err;
        cyc();
        rsp_valid = 1'b0;
      end
    end
    exp_mem_valid = 1'b1; exp_chk_out = 1'b1;
    repeat (o.wb_dly) begin
      rsp_valid = o.tmo ? 1'b1 : 1'($urandom);
      rsp_rdata = o.tmo ? o.rdata : $urandom;
      rsp_err = 1'($urandom);
      cyc();
    end
    rsp_valid = 1'b0;
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
    exp_mem_valid = 1'b0; exp_chk_out = 1'b0; exp_mem_ready = 1'b1;
  endtask

  initial begin
    op_t  o;
    exp_t e;
    reset = 1'b0;
    exe_valid = 1'b0; in_addr = '0; in_wdata = '0; in_ren = 1'b0; in_wen = 1'b0;
    in_size = 2'd0; in_unsigned = 1'b0; in_sb = '0; wb_ready = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    exp_req_addr = '0; exp_req_wdata = '0; exp_req_wstrb = '0; exp_req_wen = 1'b0;
    set_reset_exp();
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    exp_chk_out = 1'b0;

    // LB with sign extension from the top byte lane
    o = mk_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0);
    e = '0; e.has_req = 1'b1; e.req_addr = 32'h8000_0000; e.wstrb = 4'b1000;
    e.rdata = 32'hFFFF_FF80;
    do_op(o, e);

    // SH with response arriving in the request cycle
    o = mk_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 32'h0, 1'b0);
    o.rsp_dly = 4'd0;
    e = '0; e.has_req = 1'b1; e.req_addr = 32'h100; e.wstrb = 4'b1100;
    e.wdata = 32'h1234_0000; e.wen = 1'b1;
    do_op(o, e);

    // misaligned LW: no bus request, result next cycle
    o = mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0);
    e = '0; e.fault = 2'd1;
    do_op(o, e);

    // load stalled 5 cycles on req_ready, then bus error
    o = mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, 1'b1);
    o.req_dly = 4'd5; o.rsp_dly = 4'd2; o.wb_dly = 4'd2;
    e = '0; e.has_req = 1'b1; e.req_addr = 32'h200; e.wstrb = 4'b1111; e.fault = 2'd2;
    do_op(o, e);

    // LH signed and unsigned, and a non-memory op
    o = mk_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h8001_0000, 1'b0);
    e = '0; e.has_req = 1'b1; e.req_addr = 32'h0; e.wstrb = 4'b1100; e.rdata = 32'hFFFF_8001;
    do_op(o, e);
    o.uns = 1'b1; e.rdata = 32'h0000_8001;
    do_op(o, e);
    o = mk_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h55, 32'h77, 32'h0, 1'b0);
    o.wb_dly = 4'd3;
    e = '0;
    do_op(o, e);

`ifdef YSYX_24100006_LSU_TIMEOUT_EN
    o = mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1111_2222, 1'b0);
    o.tmo = 1'b1; o.wb_dly = 4'd3;
    e = '0; e.has_req = 1'b1; e.req_addr = 32'h300; e.wstrb = 4'b1111; e.fault = 2'd3;
    do_op(o, e);
`endif

    // reset asserted while waiting for a load response
    o = mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    e = model(o);
    exe_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_size = 2'd2; in_addr = 32'h40;
    in_wdata = 32'h0; in_sb = 64'h0123_4567_89AB_CDEF;
    cyc();
    exe_valid = 1'b0; exp_mem_ready = 1'b0; load_req_exp(e);
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0; exp_req_valid = 1'b0;
    cyc();
    #2;
    reset = 1'b0;
    set_reset_exp();
    cyc();
    reset = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 32'hCAFE_F00D; rsp_err = 1'b0;
    cyc();
    rsp_valid = 1'b0;
    cyc();
    exp_chk_out = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      o = '0;
      o.ren = (kind == 1) || (kind == 3);
      o.wen = (kind >= 2);
      o.size = 2'($urandom_range(0, 3));
      o.uns = 1'($urandom);
      o.addr = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (o.size == 2'd1) o.addr[0] = 1'b0;
        else if (o.size == 2'd2) o.addr[1:0] = 2'b00;
      end
      o.wdata = $urandom;
      o.sb = {$urandom, $urandom};
      o.rdata = $urandom;
      o.err = ($urandom_range(0, 4) == 0);
      o.req_dly = 4'($urandom_range(0, 3));
      o.rsp_dly = 4'($urandom_range(0, 3));
      o.wb_dly = 4'($urandom_range(0, 2));
      e = model(o);
      do_op(o, e);
    end

    cyc();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
